// File: rtl/ccff_bitstream_loader.sv
// Bitstream loader for a ccff configuration chain: serializes handshaked words MSB-first onto
// ccff_head, gates the chain with ccff_shift_en and optionally checks ccff_tail on a replay pass.
module ccff_bitstream_loader #(
   parameter int unsigned CHAIN_LEN = 48,
   parameter int unsigned WORD_W    = 8,
   parameter int unsigned CNT_W     = $clog2(2 * CHAIN_LEN + 1)
) (
   input  logic              prog_clk,
   input  logic              pReset,
   input  logic              start,
   input  logic              verify,
   input  logic [WORD_W-1:0] bs_data,
   input  logic              bs_valid,
   output logic              bs_ready,
   output logic              ccff_head,
   output logic              ccff_shift_en,
   input  logic              ccff_tail,
   output logic              busy,
   output logic              done,
   output logic              error
);

   localparam int unsigned IdxW = (WORD_W > 1) ? $clog2(WORD_W) : 1;

   localparam logic [CNT_W-1:0] ChainLen   = CNT_W'(CHAIN_LEN);
   localparam logic [CNT_W-1:0] LastSingle = CNT_W'(CHAIN_LEN - 1);
   localparam logic [CNT_W-1:0] LastDouble = CNT_W'(2 * CHAIN_LEN - 1);
   localparam logic [IdxW-1:0]  IdxTop     = IdxW'(WORD_W - 1);

   typedef enum logic [1:0] {
      StIdle,
      StWaitWord,
      StShift,
      StDone
   } state_e;

   state_e state_q, state_d;

   logic [WORD_W-1:0] shreg_q, shreg_d;
   logic [IdxW-1:0]   bit_idx_q, bit_idx_d;
   logic [CNT_W-1:0]  shift_cnt_q, shift_cnt_d;
   logic              verify_q, verify_d;
   logic              error_q, error_d;

   logic accept;
   logic last_shift;
   logic mismatch;

   assign accept     = (state_q == StWaitWord) && bs_valid;
   assign last_shift = (shift_cnt_q == (verify_q ? LastDouble : LastSingle));

   // On the replay pass the tail carries the bit sent exactly CHAIN_LEN shifts earlier.
   assign mismatch = verify_q && (shift_cnt_q >= ChainLen) && (ccff_tail != shreg_q[WORD_W-1]);

   assign error = error_q;

   // State register
   always_ff @(posedge prog_clk) begin
      if (pReset) begin
         state_q <= StIdle;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StIdle: begin
            if (start) begin
               state_d = StWaitWord;
            end
         end
         StWaitWord: begin
            if (bs_valid) begin
               state_d = StShift;
            end
         end
         StShift: begin
            if (last_shift) begin
               state_d = StDone;
            end else if (bit_idx_q == '0) begin
               state_d = StWaitWord;
            end
         end
         StDone: begin
            state_d = StIdle;
         end
         default: begin
            state_d = StIdle;
         end
      endcase
   end

   // Output logic
   always_comb begin
      bs_ready      = 1'b0;
      ccff_head     = 1'b0;
      ccff_shift_en = 1'b0;
      busy          = 1'b1;
      done          = 1'b0;
      unique case (state_q)
         StIdle: begin
            busy = 1'b0;
         end
         StWaitWord: begin
            bs_ready = 1'b1;
         end
         StShift: begin
            ccff_shift_en = 1'b1;
            ccff_head     = shreg_q[WORD_W-1];
         end
         StDone: begin
            done = 1'b1;
         end
         default: begin
            busy = 1'b0;
         end
      endcase
   end

   // Datapath registers
   always_ff @(posedge prog_clk) begin
      if (pReset) begin
         shreg_q     <= '0;
         bit_idx_q   <= '0;
         shift_cnt_q <= '0;
         verify_q    <= 1'b0;
         error_q     <= 1'b0;
      end else begin
         shreg_q     <= shreg_d;
         bit_idx_q   <= bit_idx_d;
         shift_cnt_q <= shift_cnt_d;
         verify_q    <= verify_d;
         error_q     <= error_d;
      end
   end

   always_comb begin
      shreg_d     = shreg_q;
      bit_idx_d   = bit_idx_q;
      shift_cnt_d = shift_cnt_q;
      verify_d    = verify_q;
      error_d     = error_q;

      if ((state_q == StIdle) && start) begin
         verify_d    = verify;
         shift_cnt_d = '0;
         error_d     = 1'b0;
      end

      if (accept) begin
         shreg_d   = bs_data;
         bit_idx_d = IdxTop;
      end

      if (state_q == StShift) begin
         shreg_d     = shreg_q << 1;
         bit_idx_d   = bit_idx_q - IdxW'(1);
         shift_cnt_d = shift_cnt_q + CNT_W'(1);
         if (mismatch) begin
            error_d = 1'b1;
         end
      end
   end

endmodule
